// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES encipher datapath, one round per clock
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   next       in   start enciphering block (sampled only while ready=1)
//   keylen     in   0=AES-128, 1=AES-256 (sampled with next)
//   round      out  current round index presented to the key memory
//   round_key  in   key for round, valid combinationally in the same cycle
//   block      in   plaintext, byte [127:120]=s00, column-major
//   new_block  out  ciphertext (valid while ready=1), same byte order
//   ready      out  1=idle/result valid, 0=busy
// Optional: define AES_ENC_AES256_EN to honour keylen (Nr=14 for AES-256);
// otherwise keylen is ignored and Nr=10.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (z[i] ? m : 8'h00);
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as a^254: square-and-multiply up to a^127, then square.
    always_comb begin
        inv = 8'h01;
        for (int i = 0; i < 7; i++) inv = gmul(gmul(inv, inv), a);
        inv = gmul(inv, inv);
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_encipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam logic [3:0] AES_128_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_t;

    fsm_t         fsm, fsm_next;
    logic [127:0] state_reg, state_next, sb;
    logic [3:0]   round_ctr, ctr_next, nr;
    logic         keylen_reg, keylen_next, keylen_in, ready_reg, ready_next;

`ifdef AES_ENC_AES256_EN
    assign keylen_in = keylen;
`else
    logic unused_keylen;
    assign unused_keylen = keylen;
    assign keylen_in = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    // Byte index 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    // SubBytes is byte-wise, so the sbox lanes need not follow state ordering.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.a(state_reg[8*i +: 8]), .y(sb[8*i +: 8]));
    end

    assign nr        = keylen_reg ? AES_256_ROUNDS : AES_128_ROUNDS;
    assign round     = round_ctr;
    assign new_block = state_reg;
    assign ready     = ready_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= IDLE;
            state_reg  <= '0;
            round_ctr  <= '0;
            keylen_reg <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            fsm        <= fsm_next;
            state_reg  <= state_next;
            round_ctr  <= ctr_next;
            keylen_reg <= keylen_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        fsm_next    = fsm;
        state_next  = state_reg;
        ctr_next    = round_ctr;
        keylen_next = keylen_reg;
        ready_next  = ready_reg;
        case (fsm)
            IDLE: if (next) begin
                state_next  = block;
                keylen_next = keylen_in;
                ctr_next    = 4'd0;
                ready_next  = 1'b0;
                fsm_next    = INIT;
            end
            INIT: begin
                state_next = state_reg ^ round_key;
                ctr_next   = 4'd1;
                fsm_next   = MAIN;
            end
            MAIN: begin
                state_next = mix_columns(shift_rows(sb)) ^ round_key;
                ctr_next   = round_ctr + 4'd1;
                fsm_next   = (ctr_next == nr) ? FINAL : MAIN;
            end
            FINAL: begin
                state_next = shift_rows(sb) ^ round_key;
                ctr_next   = 4'd0;
                ready_next = 1'b1;
                fsm_next   = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_encipher_block.sv
// tb_aes_encipher_block: randomized and FIPS-197 vector bench with a behavioural AES model
module tb_aes_encipher_block;
    logic         clk = 1'b0, reset = 1'b1, next = 1'b0, keylen = 1'b0, ready;
    logic [3:0]   round;
    logic [127:0] block = '0, round_key, new_block;

`ifdef AES_ENC_AES256_EN
    localparam bit AES256 = 1'b1;
`else
    localparam bit AES256 = 1'b0;
`endif

    localparam logic [255:0] C1_KEY  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] B_KEY   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1    = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_encipher_block dut (
        .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round),
        .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
    );

    logic [7:0]   sbox [256];
    logic [127:0] rk_tab [16];
    logic [127:0] traj [16];
    logic [127:0] hist [64];
    logic [127:0] m_out = '0;
    bit           m_busy = 1'b0, chk_en = 1'b0;
    int           m_step = 0, m_nr = 10, checks = 0, errors = 0;

    assign round_key = rk_tab[round];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input bit mix);
        logic [7:0] a [4][4];
        logic [7:0] b [4][4];
        logic [127:0] o;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) a[r][c] = sbox[s[127-8*(4*c+r) -: 8]];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b[r][c] = a[r][(c+r)%4];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
            o[127-8*(4*c+r) -: 8] = mix ? (gmul(8'h02, b[r][c]) ^ gmul(8'h03, b[(r+1)%4][c]) ^
                                           b[(r+2)%4][c] ^ b[(r+3)%4][c]) : b[r][c];
        return o ^ k;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Key memory model: FIPS-197 key expansion, AES-128 uses key[255:128].
    task automatic set_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nk = (AES256 && kl) ? 8 : 4;
        int nr = (AES256 && kl) ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Behavioural model: on acceptance the whole trajectory is computed, then replayed one step per clock.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_busy = 1'b0;
            m_step = 0;
            m_out  = '0;
        end else if (!m_busy) begin
            if (next) begin
                m_nr = (AES256 && keylen) ? 14 : 10;
                traj[0] = block;
                traj[1] = block ^ rk_tab[0];
                for (int r = 1; r <= m_nr; r++) traj[r+1] = enc_round(traj[r], rk_tab[r], r != m_nr);
                m_busy = 1'b1;
                m_step = 0;
                m_out  = traj[0];
            end
        end else begin
            m_step++;
            m_out = traj[m_step];
            if (m_step == m_nr + 1) m_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (ready !== !m_busy || round !== (m_busy ? 4'(m_step) : 4'd0) || new_block !== m_out) begin
                errors++;
                $display("FAIL cycle t=%0t ready=%b exp %b round=%0d exp %0d new_block=%h exp %h",
                         $time, ready, !m_busy, round, m_busy ? m_step : 0, new_block, m_out);
            end
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] blk, input bit kl);
        block  = blk;
        keylen = kl;
        next   = 1'b1;
        tick();
        next   = 1'b0;
        block  = {$urandom, $urandom, $urandom, $urandom};
        keylen = 1'($urandom);
    endtask

    task automatic wait_done(output logic [127:0] res, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (ready || lat > 40) break;
            hist[lat] = new_block;
            lat++;
        end
        res = new_block;
    endtask

    task automatic run(input string name, input logic [255:0] key, input bit kl,
                       input logic [127:0] pt, input logic [127:0] ct, input int exp_lat);
        logic [127:0] res;
        int lat;
        set_key(key, kl);
        start(pt, kl);
        wait_done(res, lat);
        check({name, "_ct"}, res, ct);
        check({name, "_lat"}, lat, exp_lat);
        tick();
    endtask

    initial begin
        logic [7:0] p, q, x;
        logic [127:0] res;
        logic [255:0] key;
        bit kl;
        int lat, n;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;
        check("sbox_00", sbox[8'h00], 8'h63);
        check("sbox_53", sbox[8'h53], 8'hed);
        check("sbox_ff", sbox[8'hff], 8'h16);

        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        tick();
        check("reset_state", {ready, round, new_block}, {1'b1, 4'd0, 128'h0});
        reset = 1'b0;
        repeat (20) tick();
        check("idle_state", {ready, round, new_block}, {1'b1, 4'd0, 128'h0});

        run("c1", C1_KEY, 1'b0, C1_PT, C1_CT, 11);
        run("appb", B_KEY, 1'b0, B_PT, B_CT, 11);
        check("appb_round1_dut", hist[2], B_R1);
        check("appb_round1_model", traj[2], B_R1);
        if (AES256) run("aes256", K256, 1'b1, C1_PT, C3_CT, 15);
        else        run("aes256_off", K256, 1'b1, C1_PT, C1_CT, 11);

        set_key(C1_KEY, 1'b0);
        start(C1_PT, 1'b0);
        tick();
        block = {$urandom, $urandom, $urandom, $urandom};
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (3) tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        wait_done(res, lat);
        check("busy_ignored_ct", res, C1_CT);
        tick();

        start(C1_PT, 1'b0);
        block = {$urandom, $urandom, $urandom, $urandom};
        next = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        check("b2b_first_ct", new_block, C1_CT);
        tick();
        next = 1'b0;
        @(negedge clk);
        check("b2b_restart_busy", ready, 1'b0);
        wait_done(res, lat);
        check("b2b_second_lat", lat, 10);
        tick();

        start(C1_PT, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (round != 4'd5 && n < 20);
        check("midreset_round5", round, 4'd5);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_state", {ready, round, new_block}, {1'b1, 4'd0, 128'h0});
        tick();
        reset = 1'b0;
        tick();
        run("c1_after_reset", C1_KEY, 1'b0, C1_PT, C1_CT, 11);

        for (int i = 0; i < 25; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kl = 1'($urandom);
            set_key(key, kl);
            start({$urandom, $urandom, $urandom, $urandom}, kl);
            wait_done(res, lat);
            check("rand_lat", lat, (AES256 && kl) ? 15 : 11);
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
